// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM (R, I-arith, L, S) with data-memory handshake and traps.
// Define MEM_WAIT_EN to add the dmemReady port, the wait counter and the bus-timeout trap.
module mc_control_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
`ifdef MEM_WAIT_EN
    input  logic        dmemReady,
`endif
    output logic        pcEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic        wdataSel,
    output logic        dataWe,
    output logic        dataRe,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        R_EXE  = 4'd2,
        I_EXE  = 4'd3,
        S_EXE  = 4'd4,
        S_MEM  = 4'd5,
        L_EXE  = 4'd6,
        L_MEM  = 4'd7,
        L_WB   = 4'd8,
        TRAP   = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cause_d;
    logic       mem_done;
    logic       mem_timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = instrCode[6:0];
    assign funct3 = instrCode[14:12];

    // Only opcode, funct3 and bit 30 steer control; the rest belongs to the datapath.
    logic unused_instr;
    assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

`ifdef MEM_WAIT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Ready wins over timeout when both land in the same cycle.
    assign mem_done    = dmemReady;
    assign mem_timeout = !dmemReady && (wait_cnt == CNT_W'(WAIT_MAX));

    // Counter is held at zero outside the memory states, so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_q != S_MEM && state_q != L_MEM) begin
            wait_cnt <= '0;
        end else if (!dmemReady) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_wait;
    assign mem_done    = 1'b1;
    assign mem_timeout = 1'b0;
    assign unused_wait = ^CNT_W'(WAIT_MAX);
`endif

    // ALU operation decode, independent of state.
    always_comb begin
        aluControl = 4'b0000;
        case (opcode)
            OP_R:    aluControl = {instrCode[30], funct3};
            OP_I:    aluControl = (funct3 == 3'b101) ? {instrCode[30], 3'b101}
                                                     : {1'b0, funct3};
            default: aluControl = 4'b0000;
        endcase
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        cause_d      = 2'd0;
        pcEn         = 1'b0;
        regFileWe    = 1'b0;
        aluSrcMuxSel = 1'b0;
        wdataSel     = 1'b0;
        dataWe       = 1'b0;
        dataRe       = 1'b0;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:    state_d = R_EXE;
                    OP_I:    state_d = I_EXE;
                    OP_S:    state_d = S_EXE;
                    OP_L:    state_d = L_EXE;
                    default: begin
                        state_d = TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            R_EXE: begin
                regFileWe = 1'b1;
                pcEn      = 1'b1;
                state_d   = FETCH;
            end
            I_EXE: begin
                aluSrcMuxSel = 1'b1;
                regFileWe    = 1'b1;
                pcEn         = 1'b1;
                state_d      = FETCH;
            end
            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = S_MEM;
            end
            S_MEM: begin
                aluSrcMuxSel = 1'b1;
                dataWe       = 1'b1;
                if (mem_done) begin
                    pcEn    = 1'b1;
                    state_d = FETCH;
                end else if (mem_timeout) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end
            end
            L_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = L_MEM;
            end
            L_MEM: begin
                aluSrcMuxSel = 1'b1;
                dataRe       = 1'b1;
                if (mem_done) begin
                    state_d = L_WB;
                end else if (mem_timeout) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end
            end
            L_WB: begin
                aluSrcMuxSel = 1'b1;
                wdataSel     = 1'b1;
                regFileWe    = 1'b1;
                pcEn         = 1'b1;
                state_d      = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // State, sticky trap flags and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            trap      <= 1'b0;
            trapCause <= 2'd0;
            instret   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP && state_q != TRAP) begin
                trap      <= 1'b1;
                trapCause <= cause_d;
            end
            if (pcEn) begin
                instret <= instret + 32'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-instruction expectations from an instruction-level model.
// Works with or without MEM_WAIT_EN defined.
module tb_mc_control_unit;

    localparam int unsigned WAIT_MAX = 15;
`ifdef MEM_WAIT_EN
    localparam int MEM_ON = 1;
`else
    localparam int MEM_ON = 0;
`endif

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
`ifdef MEM_WAIT_EN
    logic        dmemReady;
`endif
    logic        pcEn, regFileWe, aluSrcMuxSel, wdataSel, dataWe, dataRe, trap;
    logic [3:0]  aluControl;
    logic [1:0]  trapCause;
    logic [31:0] instret;
    logic [3:0]  state;

    mc_control_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .instrCode    (instrCode),
`ifdef MEM_WAIT_EN
        .dmemReady    (dmemReady),
`endif
        .pcEn         (pcEn),
        .regFileWe    (regFileWe),
        .aluControl   (aluControl),
        .aluSrcMuxSel (aluSrcMuxSel),
        .wdataSel     (wdataSel),
        .dataWe       (dataWe),
        .dataRe       (dataRe),
        .trap         (trap),
        .trapCause    (trapCause),
        .instret      (instret),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 retire, 1 trap
        logic [3:0]  alu;
        logic [3:0]  st;
        logic        src;
        logic        wds;
        int          len;
        int          nwe;
        int          nre;
        int          nwr;
        logic [31:0] ret;
        logic [1:0]  cause;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_instret = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level reference: outcome, latency and strobe counts from type and wait count.
    task automatic issue_model(input logic [31:0] ins, input int nwait);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        int         w;
        op = ins[6:0];
        f3 = ins[14:12];
        w  = nwait * MEM_ON;
        e.kind = 0; e.alu = 4'd0; e.st = 4'd0; e.src = 1'b1; e.wds = 1'b0;
        e.len = 3; e.nwe = 1; e.nre = 0; e.nwr = 0; e.ret = m_instret; e.cause = 2'd0;
        if (op == OP_R) begin
            e.alu = {ins[30], f3}; e.st = 4'd2; e.src = 1'b0;
        end else if (op == OP_I) begin
            e.alu = (f3 == 3'b101) ? {ins[30], 3'b101} : {1'b0, f3}; e.st = 4'd3;
        end else if (op == OP_L || op == OP_S) begin
            if (w > int'(WAIT_MAX)) begin
                e.kind = 1; e.cause = 2'd2; e.st = 4'd9; e.nwe = 0;
                e.len = 5 + int'(WAIT_MAX);
                if (op == OP_L) e.nre = int'(WAIT_MAX) + 1;
                else            e.nwr = int'(WAIT_MAX) + 1;
            end else if (op == OP_L) begin
                e.st = 4'd8; e.wds = 1'b1; e.len = 5 + w; e.nre = 1 + w;
            end else begin
                e.st = 4'd5; e.nwe = 0; e.len = 4 + w; e.nwr = 1 + w;
            end
        end else begin
            e.kind = 1; e.cause = 2'd1; e.st = 4'd9; e.nwe = 0; e.len = 3;
        end
        if (e.kind == 0) m_instret = m_instret + 32'd1;
        q.push_back(e);
    endtask

    // Monitor: counts cycles and strobes since the last event, scores each retire/trap.
    int   mon_cnt, mon_we, mon_re, mon_wr;
    logic prev_trap;
    exp_t me;
    always @(negedge clk) begin
        if (reset) begin
            mon_cnt = 0; mon_we = 0; mon_re = 0; mon_wr = 0; prev_trap = 1'b0;
        end else begin
            mon_cnt++;
            mon_we += int'(regFileWe);
            mon_re += int'(dataRe);
            mon_wr += int'(dataWe);
            if (pcEn || (trap && !prev_trap)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_event: pcEn=%0b trap=%0b state=%0d, expected no event", pcEn, trap, state);
                end else begin
                    me = q.pop_front();
                    chk("event_kind", {31'd0, trap}, me.kind);
                    chk("latency", mon_cnt, me.len);
                    chk("regfile_we_cycles", mon_we, me.nwe);
                    chk("data_re_cycles", mon_re, me.nre);
                    chk("data_we_cycles", mon_wr, me.nwr);
                    chk("instret", instret, me.ret);
                    chk("state_at_event", {28'd0, state}, {28'd0, me.st});
                    if (me.kind == 0) begin
                        chk("alu_control", {28'd0, aluControl}, {28'd0, me.alu});
                        chk("alu_src_sel", {31'd0, aluSrcMuxSel}, {31'd0, me.src});
                        chk("wdata_sel", {31'd0, wdataSel}, {31'd0, me.wds});
                    end else begin
                        chk("trap_cause", {30'd0, trapCause}, {30'd0, me.cause});
                        chk("trap_enables", {28'd0, pcEn, regFileWe, dataWe, dataRe}, 32'd0);
                    end
                end
                mon_cnt = 0; mon_we = 0; mon_re = 0; mon_wr = 0;
            end
            prev_trap = trap;
        end
    end

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the retire/trap edge.
    task automatic run_instr(input logic [31:0] ins, input int nwait);
        bit done;
        done = 1'b0;
        instrCode = ins;
        issue_model(ins, nwait);
        for (int c = 0; c < 400 && !done; c++) begin
`ifdef MEM_WAIT_EN
            dmemReady = (c >= 3 + nwait);
`endif
            @(negedge clk);
            done = pcEn || trap;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_timeout: no retire or trap for 0x%08h, expected one within budget", ins);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, {28'd0, state}, 32'd0);
        chk({tag, "_trap"}, {31'd0, trap}, 32'd0);
        chk({tag, "_cause"}, {30'd0, trapCause}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
        chk({tag, "_strobes"}, {26'd0, pcEn, regFileWe, aluSrcMuxSel, wdataSel, dataWe, dataRe}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        q.delete();
        m_instret = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_trap_hold(input logic [1:0] cause);
        repeat (3) @(posedge clk);
        #1;
        chk("trap_hold_state", {28'd0, state}, 32'd9);
        chk("trap_hold_flag", {31'd0, trap}, 32'd1);
        chk("trap_hold_cause", {30'd0, trapCause}, {30'd0, cause});
        chk("trap_hold_enables", {28'd0, pcEn, regFileWe, dataWe, dataRe}, 32'd0);
    endtask

    logic [31:0] ins;
    logic [6:0]  op;

    initial begin
        reset     = 1'b1;
        instrCode = 32'd0;
`ifdef MEM_WAIT_EN
        dmemReady = 1'b0;
`endif
        #1;
        check_reset_values("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(32'h002081B3, 0);       // add x3,x1,x2
        run_instr(32'h40335293, 0);       // srai x5,x6,3
        run_instr(32'h0080A383, 2);       // lw x7,8(x1), two wait cycles
        run_instr(32'h0020A223, 0);       // sw x2,4(x1)
        run_instr(32'h0020A223, int'(WAIT_MAX));  // ready on the last allowed cycle

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_R;
                1:       op = OP_I;
                2:       op = OP_L;
                default: op = OP_S;
            endcase
            ins      = $urandom;
            ins[6:0] = op;
            run_instr(ins, int'($urandom_range(0, 3)));
        end

        // Illegal opcodes trap from DECODE and stick until reset.
        ins = $urandom;
        ins[6:0] = 7'b1111111;
        run_instr(ins, 0);
        check_trap_hold(2'd1);
        do_reset("after_illegal");
        ins = $urandom;
        ins[6:0] = 7'b0110111;
        run_instr(ins, 0);
        check_trap_hold(2'd1);
        do_reset("after_lui");

`ifdef MEM_WAIT_EN
        run_instr(32'h0020A223, 1000);    // store never acknowledged
        check_trap_hold(2'd2);
        do_reset("after_timeout");
        run_instr(32'h0080A383, 1000);    // load never acknowledged
        check_trap_hold(2'd2);
        do_reset("after_ld_timeout");
`endif

        run_instr(32'h002081B3, 0);

        // Asynchronous reset in the middle of L_MEM.
        instrCode = 32'h0080A383;
`ifdef MEM_WAIT_EN
        dmemReady = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #3;
        chk("lmem_state_before_reset", {28'd0, state}, 32'd7);
        chk("lmem_data_re_before_reset", {31'd0, dataRe}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("mid_lmem");
        q.delete();
        m_instret = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(32'h40335293, 0);
        run_instr(32'h0080A383, 1);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
